// File: rtl/serializer_tx.sv
// serializer_tx: frames one word as start(0), data MSB first, [even parity under SER_PARITY_EN], STOP_BITS high bits.
// Latency: a word accepted at edge k drives its start bit from edge k+1 when the line is idle.
// Backpressure: in_ready is low while the one-word holding buffer is full; queued words follow with no idle gap.
module serializer_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  serial_out,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BCW = $clog2(DATA_WIDTH);
  localparam int SCW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_WIDTH - 1);
  localparam logic [SCW-1:0] LAST_STOP = SCW'(STOP_BITS - 1);
  localparam logic           ONE_STOP  = (STOP_BITS == 1);

`ifdef SER_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                state;
  logic                  hold_full;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [BCW-1:0]        bit_cnt;
  logic [SCW-1:0]        stop_cnt;
`ifdef SER_PARITY_EN
  logic                  parity_bit;
`endif

  assign in_ready = !hold_full;

  // Outputs are registered for the state being entered, so they line up with it on the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hold_full  <= 1'b0;
      hold_data  <= '0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= '0;
      serial_out <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef SER_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      if (in_valid && !hold_full) begin
        hold_full <= 1'b1;
        hold_data <= in_data;
      end
      frame_done <= 1'b0;

      case (state)
        IDLE: begin
          if (hold_full) begin
            shift_reg  <= hold_data;
            hold_full  <= 1'b0;
`ifdef SER_PARITY_EN
            parity_bit <= ^hold_data;
`endif
            state      <= START;
            serial_out <= 1'b0;
            busy       <= 1'b1;
          end else begin
            serial_out <= 1'b1;
            busy       <= 1'b0;
          end
        end

        START: begin
          state      <= DATA;
          bit_cnt    <= '0;
          serial_out <= shift_reg[DATA_WIDTH-1];
          shift_reg  <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
        end

        DATA: begin
          if (bit_cnt == LAST_BIT) begin
`ifdef SER_PARITY_EN
            state      <= PARITY;
            serial_out <= parity_bit;
`else
            state      <= STOP;
            serial_out <= 1'b1;
            stop_cnt   <= '0;
            frame_done <= ONE_STOP;
`endif
          end else begin
            bit_cnt    <= bit_cnt + BCW'(1);
            serial_out <= shift_reg[DATA_WIDTH-1];
            shift_reg  <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
          end
        end

`ifdef SER_PARITY_EN
        PARITY: begin
          state      <= STOP;
          serial_out <= 1'b1;
          stop_cnt   <= '0;
          frame_done <= ONE_STOP;
        end
`endif

        STOP: begin
          if (stop_cnt == LAST_STOP) begin
            // A queued word starts immediately so the line stays continuously framed.
            if (hold_full) begin
              shift_reg  <= hold_data;
              hold_full  <= 1'b0;
`ifdef SER_PARITY_EN
              parity_bit <= ^hold_data;
`endif
              state      <= START;
              serial_out <= 1'b0;
            end else begin
              state      <= IDLE;
              serial_out <= 1'b1;
              busy       <= 1'b0;
            end
          end else begin
            stop_cnt   <= stop_cnt + SCW'(1);
            frame_done <= ((stop_cnt + SCW'(1)) == LAST_STOP);
          end
        end

        default: begin
          state      <= IDLE;
          serial_out <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serializer_tx.sv
// Scoreboard bench for serializer_tx: accepted words queue expected frames, a monitor checks the line.
module tb_serializer_tx;

  localparam int DW = 8;
  localparam int SB = 1;
`ifdef SER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int F = 1 + DW + SB + PB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = 8'h55;
  logic          in_valid = 1'b1;
  logic          in_ready;
  logic          serial_out;
  logic          busy;
  logic          frame_done;

  serializer_tx #(.DATA_WIDTH(DW), .STOP_BITS(SB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .serial_out(serial_out),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] w;
    int unsigned   acc;
  } item_t;

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  item_t       exp_q[$];
  int unsigned done_q[$];
  int unsigned prev_last = 0;
  int          live_pos = -1;
  logic [63:0] last_got = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      if (fails <= 50) $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, req, cyc);
    end
  endtask

  // Expected line bits, first bit in the most significant used position.
  function automatic logic [63:0] model(input logic [DW-1:0] w);
    logic [63:0] v = '0;
    for (int i = DW - 1; i >= 0; i--) v = {v[62:0], w[i]};
`ifdef SER_PARITY_EN
    v = {v[62:0], ^w};
`endif
    for (int s = 0; s < SB; s++) v = {v[62:0], 1'b1};
    return v;
  endfunction

  // Monitor: samples just after each edge; rst seen here is the value the edge used.
  bit          m_in_frame = 0;
  int          m_pos = 0;
  logic [63:0] m_got, m_exp;
  bit          m_ctrl_ok;
  item_t       m_cur;
  initial begin : monitor
    int unsigned a, b;
    bit skip;
    int lp;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        m_in_frame = 0;
        prev_last  = 0;
        live_pos   = -1;
        check("reset_state", {in_ready, serial_out, busy, frame_done}, 4'b1100);
      end else begin
        skip = 0;
        lp   = -1;
        if (!m_in_frame && (serial_out !== 1'b1 || busy !== 1'b0)) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame", {serial_out, busy, frame_done}, 3'b100);
            skip = 1;
          end else begin
            m_cur = exp_q.pop_front();
            m_exp = model(m_cur.w);
            a = m_cur.acc + 1;
            b = prev_last + 1;
            check("start_edge", cyc, (a > b) ? a : b);
            check("ready_after_unload", in_ready, 1'b1);
            m_in_frame = 1;
            m_pos      = 0;
            m_got      = '0;
            m_ctrl_ok  = 1;
          end
        end
        if (m_in_frame) begin
          lp    = m_pos;
          m_got = {m_got[62:0], serial_out};
          if (busy !== 1'b1 || frame_done !== (m_pos == F - 1)) m_ctrl_ok = 0;
          if (m_pos == F - 1) begin
            check("frame_bits", m_got, m_exp);
            check("busy_done_pattern", m_ctrl_ok, 1'b1);
            last_got   = m_got;
            prev_last  = cyc;
            done_q.push_back(cyc);
            m_in_frame = 0;
          end
          m_pos++;
        end else if (!skip) begin
          check("idle_line", {serial_out, busy, frame_done}, 3'b100);
        end
        live_pos = lp;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge with in_valid still high.
  task automatic send(input logic [DW-1:0] w);
    int    n = 0;
    item_t it;
    in_data  = w;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      check("accept_timeout", n, 0);
      in_valid = 1'b0;
      return;
    end
    it.w   = w;
    it.acc = cyc + 1;
    exp_q.push_back(it);
    @(negedge clk);
    check("ready_low_when_full", in_ready, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while ((exp_q.size() != 0 || live_pos != -1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("drain_timeout", n, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin : stimulus
    int gap;
    int n;
    // Reset held for two edges with in_valid high: nothing may be accepted.
    repeat (2) @(negedge clk);
    check("ready_in_reset", in_ready, 1'b1);
    in_valid = 1'b0;
    rst      = 1'b0;
    repeat (3) @(negedge clk);

    // Single known word.
    send(8'hA5);
    drain();
`ifdef SER_PARITY_EN
    check("a5_pattern", last_got, 64'b01010010101);
`else
    check("a5_pattern", last_got, 64'b0101001011);
`endif

    // Back-to-back with in_valid held.
    done_q.delete();
    send(8'h00);
    send(8'hFF);
    drain();
    check("done_count", done_q.size(), 2);
    if (done_q.size() == 2) check("done_spacing", done_q[1] - done_q[0], F);

    // Reset mid-frame with a second word waiting in the holding buffer.
    send(8'h3C);
    send(8'h99);
    in_valid = 1'b0;
    n = 0;
    while (live_pos != 5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_data_bit3", live_pos, 5);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    check("ready_after_abort", in_ready, 1'b1);
    repeat (3) @(negedge clk);
    send(8'h81);
    drain();
    check("recover_81", last_got, model(8'h81));

    // Low-weight word; parity is visible when the feature is built in.
    send(8'h07);
    drain();
`ifdef SER_PARITY_EN
    check("p07_pattern", last_got, 64'b00000011111);
`else
    check("w07_pattern", last_got, 64'b0000001111);
`endif

    // Randomised traffic: held valid, short gaps and long idle gaps.
    for (int k = 0; k < 40; k++) begin
      send(DW'($urandom));
      gap = ($urandom_range(0, 3) == 0) ? F + 3 : $urandom_range(0, 2);
      if (gap != 0) begin
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        repeat (gap) @(negedge clk);
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
